// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT cipher core.
// Holds the round count, S-box / permutation layer functions (forward and
// inverse), the controller state type and the key-width dependent positions
// used by the key schedule. No ports.
package present_pkg;

   localparam int         ROUNDS     = 31;
   localparam logic [4:0] LAST_ROUND = 5'd31;
   localparam logic [4:0] FIRST_ROUND = 5'd1;

   // Position of the 5-bit round-counter xor inside the key register.
   localparam int KEY80_CTR_LSB  = 15;
   localparam int KEY128_CTR_LSB = 62;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_KEYPREP = 2'd1,
      ST_RUN     = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic int ctr_lsb(input int kw);
      return (kw == 128) ? KEY128_CTR_LSB : KEY80_CTR_LSB;
   endfunction

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] sbox64(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
      return y;
   endfunction

   function automatic logic [63:0] inv_sbox64(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_sbox4(x[4*i +: 4]);
      return y;
   endfunction

   // Bit i moves to 16*i mod 63; bit 63 stays put.
   function automatic logic [63:0] player(input logic [63:0] x);
      logic [63:0] y;
      y = 64'd0;
      for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [63:0] inv_player(input logic [63:0] x);
      logic [63:0] y;
      y = 64'd0;
      for (int i = 0; i < 63; i++) y[i] = x[(16*i) % 63];
      y[63] = x[63];
      return y;
   endfunction

endpackage

// File: rtl/present_key_schedule.sv
// Combinational PRESENT key schedule step.
//   i_key     : current round key register
//   i_round   : round counter value mixed into the key
//   o_key_fwd : next key (rotate left 61, S-box top nibble(s), xor round)
//   o_key_inv : previous key (exact inverse of the forward step)
module present_key_schedule
   import present_pkg::*;
#(
   parameter int KEY_WIDTH = 80
) (
   input  logic [KEY_WIDTH-1:0] i_key,
   input  logic [4:0]           i_round,
   output logic [KEY_WIDTH-1:0] o_key_fwd,
   output logic [KEY_WIDTH-1:0] o_key_inv
);

   localparam int CTR_LSB = ctr_lsb(KEY_WIDTH);
   localparam bit TWO_NIB = (KEY_WIDTH == 128);

   logic [KEY_WIDTH-1:0] w_rot;
   logic [KEY_WIDTH-1:0] w_fwd;
   logic [KEY_WIDTH-1:0] w_pre;

   // Forward step; the S-box and counter xor touch disjoint bits.
   always_comb begin
      w_rot = {i_key[KEY_WIDTH-62:0], i_key[KEY_WIDTH-1:KEY_WIDTH-61]};
      w_fwd = w_rot;
      w_fwd[KEY_WIDTH-1 -: 4] = sbox4(w_rot[KEY_WIDTH-1 -: 4]);
      w_fwd[KEY_WIDTH-5 -: 4] = TWO_NIB ? sbox4(w_rot[KEY_WIDTH-5 -: 4])
                                        : w_rot[KEY_WIDTH-5 -: 4];
      w_fwd[CTR_LSB +: 5] = w_rot[CTR_LSB +: 5] ^ i_round;
   end

   // Inverse step: undo the xor and S-box, then rotate right 61.
   always_comb begin
      w_pre = i_key;
      w_pre[CTR_LSB +: 5] = i_key[CTR_LSB +: 5] ^ i_round;
      w_pre[KEY_WIDTH-1 -: 4] = inv_sbox4(i_key[KEY_WIDTH-1 -: 4]);
      w_pre[KEY_WIDTH-5 -: 4] = TWO_NIB ? inv_sbox4(i_key[KEY_WIDTH-5 -: 4])
                                        : i_key[KEY_WIDTH-5 -: 4];
   end

   assign o_key_fwd = w_fwd;
   assign o_key_inv = {w_pre[60:0], w_pre[KEY_WIDTH-1:61]};

endmodule

// File: rtl/present_core_param.sv
// Round-based PRESENT encrypt/decrypt core, one round per clock.
//   clk, n_reset        : clock, asynchronous active-low reset
//   start, decrypt      : request and its direction (taken while ready=1)
//   key_in, data_in     : key and block, sampled on the accept edge
//   data_out, done      : result and its valid flag (held in DONE)
//   ready               : idle / done, next start is accepted
//   round_count         : 1..31 while working, 0 when idle
// Decrypt first walks the key schedule forward to K32 (KEYPREP), then runs
// the inverse rounds while stepping the key back down.
module present_core_param
   import present_pkg::*;
#(
   parameter int KEY_WIDTH      = 80,
   parameter bit ENABLE_DECRYPT = 1'b1
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 start,
   input  logic                 decrypt,
   input  logic [KEY_WIDTH-1:0] key_in,
   input  logic [63:0]          data_in,
   output logic [63:0]          data_out,
   output logic                 ready,
   output logic                 done,
   output logic [4:0]           round_count
);

   if ((KEY_WIDTH != 80) && (KEY_WIDTH != 128)) begin : g_bad_key_width
      $error("present_core_param: KEY_WIDTH must be 80 or 128");
   end

   state_t               r_state;
   state_t               w_next_state;
   logic [63:0]          r_block;
   logic [KEY_WIDTH-1:0] r_key;
   logic                 r_dec;
   logic [4:0]           r_round;
   logic [63:0]          r_data_out;
   logic                 r_done;

   logic                 w_ready;
   logic                 w_dec_req;
   logic [63:0]          w_rk;
   logic [63:0]          w_enc_block;
   logic [63:0]          w_dec_block;
   logic [KEY_WIDTH-1:0] w_key_fwd;
   logic [KEY_WIDTH-1:0] w_key_inv;

   assign w_ready     = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_dec_req   = ENABLE_DECRYPT ? decrypt : 1'b0;
   assign w_rk        = r_key[KEY_WIDTH-1 -: 64];
   assign w_enc_block = player(sbox64(r_block ^ w_rk));

   if (ENABLE_DECRYPT) begin : g_dec
      assign w_dec_block = inv_sbox64(inv_player(r_block ^ w_rk));
   end else begin : g_no_dec
      assign w_dec_block = 64'd0;
   end

   present_key_schedule #(.KEY_WIDTH(KEY_WIDTH)) u_key_schedule (
      .i_key     (r_key),
      .i_round   (r_round),
      .o_key_fwd (w_key_fwd),
      .o_key_inv (w_key_inv)
   );

   // Controller state register.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) w_next_state = w_dec_req ? ST_KEYPREP : ST_RUN;
            else       w_next_state = r_state;
         end
         ST_KEYPREP: begin
            if (r_round == LAST_ROUND) w_next_state = ST_RUN;
            else                       w_next_state = ST_KEYPREP;
         end
         ST_RUN: begin
            if (r_dec ? (r_round == FIRST_ROUND) : (r_round == LAST_ROUND))
               w_next_state = ST_DONE;
            else
               w_next_state = ST_RUN;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Datapath: block, key, counter and result registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_block    <= 64'd0;
         r_key      <= {KEY_WIDTH{1'b0}};
         r_dec      <= 1'b0;
         r_round    <= 5'd0;
         r_data_out <= 64'd0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_block <= data_in;
                  r_key   <= key_in;
                  r_dec   <= w_dec_req;
                  r_round <= FIRST_ROUND;
                  r_done  <= 1'b0;
               end
            end
            ST_KEYPREP: begin
               r_key   <= w_key_fwd;
               // Counter parks at 31 so the first inverse round uses r=31.
               r_round <= (r_round == LAST_ROUND) ? LAST_ROUND : r_round + 5'd1;
            end
            ST_RUN: begin
               if (r_dec) begin
                  r_block <= w_dec_block;
                  r_key   <= w_key_inv;
                  r_round <= r_round - 5'd1;
                  if (r_round == FIRST_ROUND) begin
                     r_data_out <= w_dec_block ^ w_key_inv[KEY_WIDTH-1 -: 64];
                     r_done     <= 1'b1;
                  end
               end else begin
                  r_block <= w_enc_block;
                  r_key   <= w_key_fwd;
                  if (r_round == LAST_ROUND) begin
                     r_data_out <= w_enc_block ^ w_key_fwd[KEY_WIDTH-1 -: 64];
                     r_done     <= 1'b1;
                     r_round    <= 5'd0;
                  end else begin
                     r_round <= r_round + 5'd1;
                  end
               end
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign data_out    = r_data_out;
   assign done        = r_done;
   assign ready       = w_ready;
   assign round_count = r_round;

endmodule

// File: doc/present_core_param.md
Name: present_core_param

Overview:
- Parametrised, round-based PRESENT block cipher core. Supports 80- or 128-bit keys, selected at elaboration.
- Encrypts or decrypts, with the direction chosen per operation.
- Uses a start/ready/done handshake and processes one round per clock.
- Successor to the fixed 80-bit encrypt-only round core; sits behind the bus/host wrapper as the crypto datapath.

Parameters:
- KEY_WIDTH, 80, key length. Legal values are 80 and 128; any other value is an elaboration error.
- ENABLE_DECRYPT, 1, when 0 the decrypt input is ignored, every operation is an encryption, and the inverse logic is not built.

Ports:
- clk  input  1  rising-edge clock
- n_reset  input  1  asynchronous active-low reset
- start  input  1  request; accepted only while ready=1
- decrypt  input  1  direction for the accepted request: 0 = encrypt, 1 = decrypt
- key_in  input  KEY_WIDTH  cipher key, sampled at accept
- data_in  input  64  plaintext or ciphertext, sampled at accept
- data_out  output  64  result; valid while done=1
- ready  output  1  core idle; next start will be accepted
- done  output  1  result valid
- round_count  output  5  current round counter, 1..31 while processing, 0 when idle

Behaviour:
- Reset (async, any state): state FSM=IDLE, data_out=0, done=0, ready=1, round_count=0, internal state and key registers=0.
- FSM states: IDLE, KEYPREP, RUN, DONE. ready=1 in IDLE and DONE only.
- Accept edge (start=1 and ready=1):
  - latch data_in, key_in and the direction (forced to 0 if ENABLE_DECRYPT=0); round_count<=1; done<=0.
  - next state is RUN for encrypt, KEYPREP for decrypt.
- start while ready=0 is ignored. key_in and data_in may change freely after the accept edge.
- Encrypt, RUN, one edge per round r=1..31:
  - state <= pLayer(sBox(state ^ key[KEY_WIDTH-1 -: 64])); key <= update(key, r); round_count <= r+1.
  - On the r=31 edge: data_out <= pLayer(sBox(state^K31)) ^ top64(update(key,31)); done<=1; round_count<=0; go to DONE.
  - Latency: done high 31 edges after the accept edge.
- Decrypt, KEYPREP, edges r=1..31: key <= update(key, r), so that the key register holds K32. Then round_count<=31 and go to RUN.
- Decrypt, RUN, edges r=31 down to 1:
  - state <= invSBox(invPLayer(state ^ top64(key))); key <= inv_update(key, r); round_count <= r-1.
  - On the r=1 edge: data_out <= result ^ top64(inv_update(key,1)); done<=1; go to DONE.
  - Latency: done high 62 edges after the accept edge.
- Key update rules:
  - 80-bit: rotate left 61; sBox on [79:76]; xor r into [19:15].
  - 128-bit: rotate left 61; sBox on [127:124] and on [123:120]; xor r into [66:62].
  - inv_update applies the exact inverse in reverse order: xor r, invSBox on the same nibbles, rotate right 61.
- DONE: data_out and done hold until the next accepted start. A start in DONE is accepted in the same cycle (back-to-back); done drops on that edge.
- Reset mid-operation aborts the operation; no partial result is ever flagged done.
- sBox table: C56B90AD3EF84712. pLayer: bit i moves to 16·i mod 63, with bit 63 fixed.

Decomposition:
- Package present_pkg holds:
  - the ROUNDS=31 constant;
  - the sBox, invSBox, pLayer and invPLayer functions;
  - the FSM state typedef;
  - key-width localparams, including the counter-xor bit positions.
- Sub-module present_key_schedule (parameter KEY_WIDTH) provides combinational update and inv_update for a given key and round; the core instantiates it once.

Test Plan:
- KEY_WIDTH=80, encrypt, key=0, data_in=0 -> data_out=5579c1387b228445; done rises exactly 31 cycles after accept; round_count sequences 1..31 then 0.
- KEY_WIDTH=80, encrypt, key=FFFFFFFFFFFFFFFFFFFF, data_in=0 -> e72c46c0f5945049. Also data_in=FFFFFFFFFFFFFFFF with key=0 -> a112ffc72f68417b.
- KEY_WIDTH=128, encrypt, key=0, data_in=0 -> 96db702a2e6900af.
- KEY_WIDTH=80, decrypt, key=0, data_in=5579c1387b228445 -> data_out=0 after 62 cycles. Then a back-to-back encrypt issued in the DONE cycle is accepted and returns 5579c1387b228445.
- Pulse start at cycle 10 of a running encrypt with different data -> ignored; the original result is unchanged and ready stays 0 until done.
- Assert n_reset=0 at round 15 -> all outputs return to reset values immediately. After release, a new encrypt completes correctly with no stale done.
